// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants and fetch-stage types
package mips_pkg;

   localparam logic [31:0] NOP_INST           = 32'h0000_0000;
   localparam int          WORD_BYTES         = 4;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam int          DEFAULT_IMEM_DEPTH = 32;

   typedef enum logic [1:0] {
      PC_SEQ,
      PC_HOLD,
      PC_BRANCH,
      PC_JUMP
   } pc_src_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_select.sv
// rtl/pc_select.sv - next-PC priority mux with redirect alignment and misalignment detect
module pc_select
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic [31:0] next_pc_o,
   output logic        misaligned_o
);

   pc_src_e src;

   // Redirects outrank stall so a stalled pipe still follows a taken branch or jump.
   always_comb begin
      src = PC_SEQ;
      if (jump_i) begin
         src = PC_JUMP;
      end else if (branch_taken_i) begin
         src = PC_BRANCH;
      end else if (stall_i) begin
         src = PC_HOLD;
      end
   end

   always_comb begin
      next_pc_o    = pc_plus4_i;
      misaligned_o = 1'b0;
      case (src)
         PC_JUMP: begin
            next_pc_o    = word_align(jump_target_i);
            misaligned_o = (jump_target_i[1:0] != 2'b00);
         end
         PC_BRANCH: begin
            next_pc_o    = word_align(branch_target_i);
            misaligned_o = (branch_target_i[1:0] != 2'b00);
         end
         PC_HOLD: next_pc_o = pc_i;
         default: next_pc_o = pc_plus4_i;
      endcase
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS IF stage: PC register, IF/ID register, fetch counter and fault flags
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_inst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic        misaligned,
   output logic        pc_oob
);

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] pc_plus4;
   logic        redirect_misaligned;

   assign pc_plus4 = pc_q + 32'(WORD_BYTES);
   assign pc_oob   = ({2'b00, pc_q[31:2]} >= DEPTH_W);

   pc_select u_pc_select (
      .pc_i            (pc_q),
      .pc_plus4_i      (pc_plus4),
      .stall_i         (stall),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .jump_i          (jump),
      .jump_target_i   (jump_target),
      .next_pc_o       (pc_d),
      .misaligned_o    (redirect_misaligned)
   );

   // A redirect without flush still captures the current word: that is the delay slot.
   always_comb begin
      inst_d     = inst_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      count_d    = count_q;
      if (flush) begin
         inst_d     = NOP_INST;
         pc_plus4_d = 32'h0;
         valid_d    = 1'b0;
      end else if (!stall) begin
         pc_plus4_d = pc_plus4;
         if (pc_oob) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
         end else begin
            inst_d  = imem_inst;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
         end
      end
   end

   assign misaligned_d = misaligned_q | redirect_misaligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         inst_q       <= NOP_INST;
         pc_plus4_q   <= 32'h0;
         valid_q      <= 1'b0;
         count_q      <= 32'h0;
         misaligned_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         pc_plus4_q   <= pc_plus4_d;
         valid_q      <= valid_d;
         count_q      <= count_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign imem_pc        = pc_q;
   assign if_id_inst     = inst_q;
   assign if_id_pc_plus4 = pc_plus4_q;
   assign if_id_valid    = valid_q;
   assign fetch_count    = count_q;
   assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_pc;
   logic [31:0] imem_inst;
   logic        stall, flush, branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] if_id_inst, if_id_pc_plus4, fetch_count;
   logic        if_id_valid, misaligned, pc_oob;

   logic [31:0] mem [DEPTH];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pp4;
      logic [31:0] cnt;
      logic        valid;
      logic        mis;
      logic        oob;
   } exp_t;

   exp_t exp_q[$];

   logic [31:0] m_pc, m_inst, m_pp4, m_cnt;
   logic        m_valid, m_mis;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign imem_inst = (imem_pc[31:7] == 25'h0) ? mem[imem_pc[6:2]] : 32'hDEAD_BEEF;

   instruction_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_pc        (imem_pc),
      .imem_inst      (imem_inst),
      .stall          (stall),
      .flush          (flush),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .if_id_inst     (if_id_inst),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .fetch_count    (fetch_count),
      .misaligned     (misaligned),
      .pc_oob         (pc_oob)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_pp4 = 32'h0; m_cnt = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0;
   endtask

   // One clock of stimulus; the expected post-edge state is queued for the monitor.
   task automatic step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
      logic [31:0] widx;
      exp_t e;
      @(negedge clk); #1;
      stall = s; flush = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
      widx = m_pc >> 2;
      if (f) begin
         m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
         m_pp4 = m_pc + 32'd4;
         if (widx >= DEPTH) begin
            m_inst = 32'h0; m_valid = 1'b0;
         end else begin
            m_inst = mem[widx[4:0]]; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
         end
      end
      if (j) begin
         if (jt[1:0] != 2'b00) m_mis = 1'b1;
         m_pc = jt & ~32'h3;
      end else if (b) begin
         if (bt[1:0] != 2'b00) m_mis = 1'b1;
         m_pc = bt & ~32'h3;
      end else if (!s) begin
         m_pc = m_pc + 32'd4;
      end
      e.pc = m_pc; e.inst = m_inst; e.pp4 = m_pp4; e.cnt = m_cnt;
      e.valid = m_valid; e.mis = m_mis; e.oob = ((m_pc >> 2) >= DEPTH);
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   task automatic settle();
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 0; flush = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else t = 32'($urandom_range(0, 40 * 4 + 3));
      return t;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_imem_pc", imem_pc, e.pc);
            chk("sb_inst", if_id_inst, e.inst);
            chk("sb_pc_plus4", if_id_pc_plus4, e.pp4);
            chk("sb_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
            chk("sb_count", fetch_count, e.cnt);
            chk("sb_misaligned", {31'h0, misaligned}, {31'h0, e.mis});
            chk("sb_pc_oob", {31'h0, pc_oob}, {31'h0, e.oob});
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin : driver
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
      rst_n = 1'b0;
      stall = 0; flush = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_imem_pc", imem_pc, 32'h0);
      chk("rst_inst", if_id_inst, 32'h0);
      chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("rst_count", fetch_count, 32'h0);
      rst_n = 1'b1;

      run(4);
      settle();
      chk("run_inst", if_id_inst, 32'h1000_0003);
      chk("run_pc_plus4", if_id_pc_plus4, 32'd16);
      chk("run_count", fetch_count, 32'd4);

      do_reset();
      run(2);
      step(1, 0, 0, 32'h0, 0, 32'h0);
      step(1, 0, 0, 32'h0, 0, 32'h0);
      settle();
      chk("stall_pc", imem_pc, 32'h8);
      chk("stall_inst", if_id_inst, 32'h1000_0001);
      chk("stall_count", fetch_count, 32'd2);
      run(1);
      settle();
      chk("resume_inst", if_id_inst, 32'h1000_0002);

      step(1, 0, 1, 32'h20, 1, 32'h10);
      settle();
      chk("prio_pc", imem_pc, 32'h10);
      run(1);
      settle();
      chk("prio_inst", if_id_inst, 32'h1000_0004);

      step(1, 1, 0, 32'h0, 0, 32'h0);
      settle();
      chk("fs_valid", {31'h0, if_id_valid}, 32'h0);
      chk("fs_inst", if_id_inst, 32'h0);
      chk("fs_pc", imem_pc, 32'h14);
      chk("fs_count", fetch_count, 32'd4);

      step(0, 0, 1, 32'h43, 0, 32'h0);
      settle();
      chk("mis_pc", imem_pc, 32'h40);
      chk("mis_flag", {31'h0, misaligned}, 32'h1);
      run(10);
      settle();
      chk("mis_sticky", {31'h0, misaligned}, 32'h1);

      step(0, 0, 0, 32'h0, 1, 32'h80);
      settle();
      chk("oob_flag", {31'h0, pc_oob}, 32'h1);
      run(1);
      settle();
      chk("oob_valid", {31'h0, if_id_valid}, 32'h0);
      chk("oob_inst", if_id_inst, 32'h0);
      chk("oob_count", fetch_count, 32'd16);

      step(0, 0, 0, 32'h0, 1, 32'h40);
      settle();
      chk("pre_arst_pc", imem_pc, 32'h40);
      @(negedge clk); #1;
      rst_n = 1'b0;
      stall = 0; flush = 0; branch_taken = 0; jump = 0;
      #1;
      chk("arst_pc", imem_pc, 32'h0);
      chk("arst_inst", if_id_inst, 32'h0);
      chk("arst_pc_plus4", if_id_pc_plus4, 32'h0);
      chk("arst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("arst_count", fetch_count, 32'h0);
      chk("arst_misaligned", {31'h0, misaligned}, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run(1);
      settle();
      chk("arst_first_inst", if_id_inst, 32'h1000_0000);
      chk("arst_first_valid", {31'h0, if_id_valid}, 32'h1);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, rand_target(),
              $urandom_range(0, 9) == 0, rand_target());
      end
      settle();
      chk("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
